// File: rtl/buf_ctrl_pkg.sv
// buf_ctrl_pkg: shared state and grant encodings for the buffer access controller.
package buf_ctrl_pkg;

  // Read-job sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Which requester the arbiter granted on its last contended cycle
  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

  // Starting from "read" makes the first contended cycle go to the loader
  localparam grant_e LAST_GRANT_RST = GNT_RD;

  // Round-robin choice: the side that did not win last time
  function automatic grant_e other_grant(input grant_e g);
    grant_e r;
    case (g)
      GNT_RD:  r = GNT_WR;
      GNT_WR:  r = GNT_RD;
      default: r = GNT_WR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/buf_access_ctrl_rr_arb2.sv
// rr_arb2: two-requester (write/read) round-robin arbiter.
// Uncontended requests win outright; contended cycles alternate using last_grant.
module rr_arb2
  import buf_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  grant_e r_last_grant;
  grant_e w_pick;
  logic   w_contend;

  assign w_contend = i_req_wr & i_req_rd;
  assign w_pick    = other_grant(r_last_grant);

  // Grant decode; both grants are held low while reset is asserted
  always_comb begin
    o_gnt_wr = 1'b0;
    o_gnt_rd = 1'b0;
    if (i_rst) begin
      o_gnt_wr = 1'b0;
      o_gnt_rd = 1'b0;
    end else begin
      case ({i_req_wr, i_req_rd})
        2'b10: o_gnt_wr = 1'b1;
        2'b01: o_gnt_rd = 1'b1;
        2'b11: begin
          if (w_pick == GNT_WR) begin
            o_gnt_wr = 1'b1;
          end else begin
            o_gnt_rd = 1'b1;
          end
        end
        default: begin
          o_gnt_wr = 1'b0;
          o_gnt_rd = 1'b0;
        end
      endcase
    end
  end

  // Remember the winner of each contended cycle only
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= LAST_GRANT_RST;
    end else if (w_contend) begin
      r_last_grant <= w_pick;
    end
  end

endmodule

// File: rtl/buf_access_ctrl.sv
// buf_access_ctrl: shares one RAM between a loader write port and a sequential
// read job (base/length) feeding a valid/ready consumer. Reads use the RAM's
// registered output directly, so a word stays on rd_data until the next read.
module buf_access_ctrl
  import buf_ctrl_pkg::*;
#(
  parameter int DW       = 8,
  parameter int ADDR_DW  = 4,
  parameter int RAM_SIZE = 2**ADDR_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_DW-1:0] wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               start,
  input  logic [ADDR_DW-1:0] rd_base,
  input  logic [ADDR_DW:0]   rd_len,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic               ram_WRenable,
  output logic               ram_RAenable,
  output logic [DW-1:0]      ram_din,
  output logic [ADDR_DW-1:0] ram_addr_w,
  output logic [ADDR_DW-1:0] ram_addr_r,
  input  logic [DW-1:0]      ram_dout
);

  localparam logic [ADDR_DW:0] RAM_SIZE_W = (ADDR_DW+1)'(RAM_SIZE);
  localparam logic [ADDR_DW:0] CNT_ONE    = (ADDR_DW+1)'(1);
  localparam logic [ADDR_DW:0] CNT_ZERO   = (ADDR_DW+1)'(0);

  state_e             r_state;
  logic [ADDR_DW-1:0] r_base_q;
  logic [ADDR_DW:0]   r_len_q;
  logic [ADDR_DW:0]   r_issued;
  logic               r_rd_valid;

  logic               w_rd_issuable;
  logic               w_gnt_wr;
  logic               w_gnt_rd;
  logic               w_drain_done;
  logic [ADDR_DW:0]   w_addr_sum;
  logic [ADDR_DW-1:0] w_addr_rd;

  // A read may go out only while the job has words left and the output slot
  // is empty or being emptied this cycle (keeps rd_data stable under stall)
  assign w_rd_issuable = (r_state == ST_RUN) && (r_issued < r_len_q) &&
                         (!r_rd_valid || rd_ready);

  // The job ends once the last word has left the output slot
  assign w_drain_done  = (r_state == ST_DRAIN) && (!r_rd_valid || rd_ready);

  rr_arb2 u_arb (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req_wr (wr_valid),
    .i_req_rd (w_rd_issuable),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  // base + issued never exceeds 2*RAM_SIZE-2, so one conditional subtract wraps it
  assign w_addr_sum = {1'b0, r_base_q} + r_issued;

  // Wrap the read address into the RAM depth
  always_comb begin
    w_addr_rd = ADDR_DW'(w_addr_sum);
    if (w_addr_sum >= RAM_SIZE_W) begin
      w_addr_rd = ADDR_DW'(w_addr_sum - RAM_SIZE_W);
    end else begin
      w_addr_rd = ADDR_DW'(w_addr_sum);
    end
  end

  assign wr_ready     = w_gnt_wr;
  assign ram_WRenable = w_gnt_wr;
  assign ram_addr_w   = wr_addr;
  assign ram_din      = wr_data;
  assign ram_RAenable = w_gnt_rd;
  assign ram_addr_r   = w_addr_rd;
  assign rd_data      = ram_dout;
  assign rd_valid     = r_rd_valid;
  assign busy         = (r_state != ST_IDLE);
  // done is decoded so it lines up with the final handshake; never during reset
  assign done         = w_drain_done & ~rst;

  // Job sequencer: latch the job on start, count issued reads, drain, finish
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_base_q <= {ADDR_DW{1'b0}};
      r_len_q  <= CNT_ZERO;
      r_issued <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base_q <= rd_base;
            r_len_q  <= rd_len;
            r_issued <= CNT_ZERO;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_gnt_rd) begin
            r_issued <= r_issued + CNT_ONE;
          end
          if (r_issued == r_len_q) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output slot: filled the cycle after a read, emptied by a bare handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else if (w_gnt_rd) begin
      r_rd_valid <= 1'b1;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buf_access_ctrl.sv
// tb_buf_access_ctrl: directed and randomized checks of buf_access_ctrl against
// a shadow memory and per-job expected word lists.
module tb_buf_access_ctrl;

  localparam int DW       = 8;
  localparam int ADDR_DW  = 4;
  localparam int RAM_SIZE = 16;
  localparam int TR_MAX   = 8192;

  logic               clk = 1'b0;
  logic               rst, wr_valid, wr_ready, start, busy, done;
  logic               rd_valid, rd_ready, ram_WRenable, ram_RAenable;
  logic [ADDR_DW-1:0] wr_addr, rd_base, ram_addr_w, ram_addr_r;
  logic [ADDR_DW:0]   rd_len;
  logic [DW-1:0]      wr_data, rd_data, ram_din, ram_dout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc    = 0;

  logic [DW-1:0]      ram     [0:RAM_SIZE-1];
  logic [DW-1:0]      exp_mem [0:RAM_SIZE-1];
  logic               tr_we   [0:TR_MAX-1];
  logic               tr_re   [0:TR_MAX-1];
  logic [ADDR_DW-1:0] q_raddr [$];
  logic [DW-1:0]      q_words [$];
  int                 q_wcyc  [$];
  int                 q_done  [$];
  logic [DW-1:0]      exp_words [$];
  logic [ADDR_DW-1:0] exp_raddr [$];
  logic               prev_hold = 1'b0;
  logic [DW-1:0]      prev_data = 8'h00;

  buf_access_ctrl #(.DW(DW), .ADDR_DW(ADDR_DW), .RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_base(rd_base), .rd_len(rd_len), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_WRenable(ram_WRenable), .ram_RAenable(ram_RAenable), .ram_din(ram_din),
    .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write wins if both enables were ever high
  always @(posedge clk) begin
    if (ram_WRenable) ram[ram_addr_w] <= ram_din;
    else if (ram_RAenable) ram_dout <= ram[ram_addr_r];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check per-cycle rules, record events
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_we", {31'd0, ram_WRenable}, 32'd0);
      check("rst_re", {31'd0, ram_RAenable}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end else begin
      check("excl", {31'd0, ram_WRenable & ram_RAenable}, 32'd0);
      check("wr_ready_eq_we", {31'd0, wr_ready}, {31'd0, ram_WRenable});
      if (!wr_valid) check("no_req_no_wgrant", {31'd0, wr_ready}, 32'd0);
      else if (!ram_RAenable) check("wr_grant", {31'd0, wr_ready}, 32'd1);
      if (ram_RAenable) begin
        check("re_not_stalled", {31'd0, (!rd_valid || rd_ready)}, 32'd1);
        check("re_busy", {31'd0, busy}, 32'd1);
        q_raddr.push_back(ram_addr_r);
      end
      if (wr_ready) begin
        check("wr_addr_pass", {28'd0, ram_addr_w}, {28'd0, wr_addr});
        check("wr_data_pass", {24'd0, ram_din}, {24'd0, wr_data});
        exp_mem[wr_addr] = wr_data;
      end
      if (prev_hold) check("rd_hold", {24'd0, rd_data}, {24'd0, prev_data});
      if (rd_valid && rd_ready) begin
        q_words.push_back(rd_data);
        q_wcyc.push_back(cyc);
      end
      if (done) q_done.push_back(cyc);
    end
    if (cyc < TR_MAX) begin
      tr_we[cyc] = ram_WRenable;
      tr_re[cyc] = ram_RAenable;
    end
    prev_hold = !rst && rd_valid && !rd_ready;
    prev_data = rd_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    q_raddr.delete(); q_words.delete(); q_wcyc.delete(); q_done.delete();
  endtask

  // Pulse start for one cycle and build the expected word/address lists
  task automatic launch(input logic [ADDR_DW-1:0] base, input logic [ADDR_DW:0] len);
    exp_words.delete(); exp_raddr.delete();
    for (int k = 0; k < int'(len); k++) begin
      exp_raddr.push_back(ADDR_DW'((int'(base) + k) % RAM_SIZE));
      exp_words.push_back(exp_mem[(int'(base) + k) % RAM_SIZE]);
    end
    start = 1'b1; rd_base = base; rd_len = len; s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // mode 0: quiet, 1: loader always requesting, 2: random loader and consumer
  task automatic drive(input int mode);
    if (mode == 1) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_DW'(8 + (cyc % 8));
      wr_data  = exp_mem[wr_addr];
    end else if (mode == 2) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = ADDR_DW'($urandom_range(0, RAM_SIZE - 1));
      wr_data  = exp_mem[wr_addr];
      rd_ready = ($urandom_range(0, 3) != 0);
    end else begin
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int mode, input int budget);
    int n = 0;
    while (q_done.size() == 0 && n < budget) begin
      drive(mode);
      tick();
      n++;
    end
    check("done_timeout", {31'd0, q_done.size() != 0}, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic check_job(input string tag, input int len);
    check({tag, "_nwords"}, q_words.size(), len);
    check({tag, "_nreads"}, q_raddr.size(), len);
    check({tag, "_ndone"}, q_done.size(), 1);
    for (int k = 0; k < len && k < q_words.size(); k++)
      check($sformatf("%s_word%0d", tag, k), {24'd0, q_words[k]}, {24'd0, exp_words[k]});
    for (int k = 0; k < len && k < q_raddr.size(); k++)
      check($sformatf("%s_raddr%0d", tag, k), {28'd0, q_raddr[k]}, {28'd0, exp_raddr[k]});
  endtask

  initial begin
    int len_r, d;
    logic [ADDR_DW-1:0] base_r;

    // Reset with a pending write request: nothing may be granted
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'h55;
    start = 1'b0; rd_base = 4'd0; rd_len = 5'd0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; wr_valid = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    // Preload A0+i
    for (int i = 0; i < RAM_SIZE; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_DW'(i); wr_data = 8'hA0 + DW'(i);
      tick();
    end
    wr_valid = 1'b0;

    // Streaming job with consumer always ready
    clear_mon(); rd_ready = 1'b1;
    launch(4'd0, 5'd4);
    wait_done(0, 50);
    check_job("basic", 4);
    for (int k = 0; k < 4 && k < q_words.size(); k++) begin
      check($sformatf("basic_val%0d", k), {24'd0, q_words[k]}, 32'hA0 + k);
      check($sformatf("basic_cyc%0d", k), q_wcyc[k], s_cyc + 2 + k);
    end
    if (q_done.size() > 0) check("basic_done_cyc", q_done[0], s_cyc + 6);
    tick();
    check("basic_idle", {31'd0, busy}, 32'd0);

    // Address wrap
    clear_mon();
    launch(4'd14, 5'd4);
    wait_done(0, 50);
    check_job("wrap", 4);
    if (q_raddr.size() == 4) begin
      check("wrap_a0", {28'd0, q_raddr[0]}, 32'd14);
      check("wrap_a1", {28'd0, q_raddr[1]}, 32'd15);
      check("wrap_a2", {28'd0, q_raddr[2]}, 32'd0);
      check("wrap_a3", {28'd0, q_raddr[3]}, 32'd1);
    end

    // Consumer stall for three cycles mid-job
    clear_mon();
    launch(4'd2, 5'd6);
    tick(); tick();
    rd_ready = 1'b0;
    d = q_raddr.size();
    tick(); tick(); tick();
    check("stall_no_reads", q_raddr.size(), d);
    check("stall_valid", {31'd0, rd_valid}, 32'd1);
    rd_ready = 1'b1;
    wait_done(0, 50);
    check_job("stall", 6);

    // Zero-length job, plus a start while busy that must be ignored
    clear_mon();
    launch(4'd5, 5'd0);
    check("zero_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; rd_base = 4'd0; rd_len = 5'd3;
    tick();
    start = 1'b0;
    wait_done(0, 20);
    if (q_done.size() > 0) check("zero_done_cyc", q_done[0], s_cyc + 2);
    for (int i = 0; i < 4; i++) tick();
    check("zero_nreads", q_raddr.size(), 0);
    check("zero_nwords", q_words.size(), 0);
    check("zero_ndone", q_done.size(), 1);
    check("zero_idle", {31'd0, busy}, 32'd0);

    // Loader requesting throughout: strict alternation, write first
    clear_mon();
    drive(1);
    launch(4'd0, 5'd6);
    wait_done(1, 60);
    check_job("contend", 6);
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("contend_we%0d", k), {31'd0, tr_we[s_cyc + k]}, {31'd0, (k % 2) == 1});
      check($sformatf("contend_re%0d", k), {31'd0, tr_re[s_cyc + k]}, {31'd0, (k % 2) == 0});
    end

    // Reset on the third read of a long job
    clear_mon();
    launch(4'd0, 5'd8);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_nreads", q_raddr.size(), 2);
    for (int i = 0; i < 3; i++) tick();
    check("abort_no_done", q_done.size(), 0);
    check("abort_quiet", q_raddr.size(), 2);
    clear_mon();
    launch(4'd4, 5'd3);
    wait_done(0, 50);
    check_job("after_abort", 3);

    // Randomized jobs with random loader traffic and consumer backpressure
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        wr_valid = 1'b1;
        wr_addr  = ADDR_DW'($urandom_range(0, RAM_SIZE - 1));
        wr_data  = DW'($urandom_range(0, 255));
        tick();
      end
      wr_valid = 1'b0;
      clear_mon();
      base_r = ADDR_DW'($urandom_range(0, RAM_SIZE - 1));
      len_r  = $urandom_range(0, RAM_SIZE);
      drive(2);
      launch(base_r, (ADDR_DW+1)'(len_r));
      wait_done(2, 400);
      check_job($sformatf("rnd%0d", j), len_r);
      if (len_r == 0) begin
        if (q_done.size() > 0) check("rnd_zero_done", q_done[0], s_cyc + 2);
      end else if (q_done.size() > 0 && q_wcyc.size() > 0) begin
        d = q_done[0] - q_wcyc[q_wcyc.size() - 1];
        check("rnd_done_lat", {31'd0, (d == 0 || d == 1)}, 32'd1);
      end
      rd_ready = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
